// File: rtl/fpu_normalize_round_pkg.sv
// Shared definitions for the FPU normalize/round/pack stage.
//   FP_BIAS     single-precision exponent bias
//   FP_EXP_MAX  biased exponent value that encodes infinity
//   FP_FRAC_W   stored fraction width of an IEEE-754 single
//   e_norm_states  state encoding of the normalize/round FSM
package fpu_normalize_round_pkg;

  localparam int FP_BIAS    = 127;
  localparam int FP_EXP_MAX = 2 * FP_BIAS + 1;
  localparam int FP_FRAC_W  = 23;

  typedef enum logic [2:0] {
    norm_idle_st,
    norm_check_st,
    norm_shift_right_st,
    norm_shift_left_st,
    norm_round_st,
    norm_round_adj_st,
    norm_pack_st,
    norm_valid_st
  } e_norm_states;

endpackage

// File: rtl/fpu_round_rne.sv
// Round-to-nearest-even of a 23-bit fraction given guard, round and sticky bits.
//   frac          fraction before rounding (hidden 1 implied above it)
//   guard_bit     first bit below the fraction lsb
//   round_bit     second bit below the fraction lsb
//   sticky_bit    OR of every remaining lower bit
//   frac_rounded  {carry, fraction} after the increment; carry set means 1.11..1 rolled to 10.00..0
//   inexact       any discarded bit was nonzero
module fpu_round_rne
  import fpu_normalize_round_pkg::*;
(
  input  logic [FP_FRAC_W-1:0] frac,
  input  logic                 guard_bit,
  input  logic                 round_bit,
  input  logic                 sticky_bit,
  output logic [FP_FRAC_W:0]   frac_rounded,
  output logic                 inexact
);

  // Ties (G=1, R=S=0) go up only when that makes the lsb even.
  function automatic logic rne_round_up(input logic lsb, input logic g, input logic r,
                                        input logic s);
    return g & (r | s | lsb);
  endfunction

  always_comb begin
    frac_rounded = {1'b0, frac} +
                   {{FP_FRAC_W{1'b0}}, rne_round_up(frac[0], guard_bit, round_bit, sticky_bit)};
    inexact      = guard_bit | round_bit | sticky_bit;
  end

endmodule

// File: rtl/fpu_normalize_round.sv
// Post-arithmetic FPU stage: normalizes a raw sign/exponent/mantissa one bit per
// cycle, rounds to nearest-even and packs an IEEE-754 single (flush-to-zero).
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start          load operands (honoured only when idle)
//   sign_in        result sign
//   exp_in         signed biased exponent of mant_in
//   mant_in        raw mantissa, top two bits are the integer part
//   busy           operation in progress (after start accepted, until result_valid)
//   result_valid   result and flags stable, held until ack
//   ack            consumer took the result
//   result         packed single-precision word
//   flag_zero / flag_ovf / flag_unf / flag_inexact  result classification
module fpu_normalize_round
  import fpu_normalize_round_pkg::*;
#(
  parameter int MANT_IN_W = 48,
  parameter int EXP_W     = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        sign_in,
  input  logic signed [EXP_W-1:0]     exp_in,
  input  logic        [MANT_IN_W-1:0] mant_in,
  output logic                        busy,
  output logic                        result_valid,
  input  logic                        ack,
  output logic        [31:0]          result,
  output logic                        flag_zero,
  output logic                        flag_ovf,
  output logic                        flag_unf,
  output logic                        flag_inexact
);

  localparam int MANT_TOP = MANT_IN_W - 1;
  // Bit index of the fraction lsb once the leading one sits at MANT_TOP-1.
  localparam int FRAC_LSB = MANT_IN_W - 2 - FP_FRAC_W;

  localparam logic signed [EXP_W:0] EXP_ZERO  = '0;
  localparam logic signed [EXP_W:0] EXP_ONE   = (EXP_W + 1)'(1);
  localparam logic signed [EXP_W:0] EXP_INF_S = (EXP_W + 1)'(FP_EXP_MAX);

  e_norm_states state, state_next;

  logic                        sign_r;
  logic signed [EXP_W:0]       exp_r;
  logic        [MANT_IN_W-1:0] mant_r;
  logic                        sticky_r;
  logic                        zero_r;
  logic                        unf_r;
  logic                        inexact_r;
  logic        [FP_FRAC_W-1:0] frac_r;

  logic        [MANT_IN_W-1:0] mant_shl;
  logic signed [EXP_W:0]       exp_dec;
  logic        [FP_FRAC_W:0]   frac_rounded;
  logic                        rnd_inexact;

  assign mant_shl = mant_r << 1;
  assign exp_dec  = exp_r - EXP_ONE;

  fpu_round_rne u_round (
    .frac         (mant_r[MANT_TOP-2 -: FP_FRAC_W]),
    .guard_bit    (mant_r[FRAC_LSB-1]),
    .round_bit    (mant_r[FRAC_LSB-2]),
    .sticky_bit   ((|mant_r[FRAC_LSB-3:0]) | sticky_r),
    .frac_rounded (frac_rounded),
    .inexact      (rnd_inexact)
  );

  assign busy         = (state != norm_idle_st) && (state != norm_valid_st);
  assign result_valid = (state == norm_valid_st);

  always_ff @(posedge clk) begin
    if (rst) state <= norm_idle_st;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      norm_idle_st:        if (start) state_next = norm_check_st;
      norm_check_st: begin
        if (mant_r == '0)            state_next = norm_pack_st;
        else if (mant_r[MANT_TOP])   state_next = norm_shift_right_st;
        else if (!mant_r[MANT_TOP-1]) state_next = norm_shift_left_st;
        else                         state_next = norm_round_st;
      end
      norm_shift_right_st: state_next = norm_round_st;
      // Underflow wins over reaching normal form on the same shift.
      norm_shift_left_st: begin
        if (exp_dec <= EXP_ZERO)      state_next = norm_pack_st;
        else if (mant_shl[MANT_TOP-1]) state_next = norm_round_st;
      end
      norm_round_st:       state_next = frac_rounded[FP_FRAC_W] ? norm_round_adj_st : norm_pack_st;
      norm_round_adj_st:   state_next = norm_pack_st;
      norm_pack_st:        state_next = norm_valid_st;
      norm_valid_st:       if (ack) state_next = norm_idle_st;
      default:             state_next = norm_idle_st;
    endcase
  end

  // Working datapath: only meaningful between start and pack, so left unreset.
  always_ff @(posedge clk) begin
    case (state)
      norm_idle_st: if (start) begin
        sign_r    <= sign_in;
        exp_r     <= {exp_in[EXP_W-1], exp_in};
        mant_r    <= mant_in;
        sticky_r  <= 1'b0;
        zero_r    <= 1'b0;
        unf_r     <= 1'b0;
        inexact_r <= 1'b0;
      end
      norm_check_st: if (mant_r == '0) zero_r <= 1'b1;
      norm_shift_right_st: begin
        mant_r   <= mant_r >> 1;
        sticky_r <= sticky_r | mant_r[0];
        exp_r    <= exp_r + EXP_ONE;
      end
      norm_shift_left_st: begin
        mant_r <= mant_shl;
        exp_r  <= exp_dec;
        if (exp_dec <= EXP_ZERO) unf_r <= 1'b1;
      end
      norm_round_st: begin
        frac_r    <= frac_rounded[FP_FRAC_W-1:0];
        inexact_r <= rnd_inexact;
      end
      // Carry out of the rounding add: significand is exactly 2.0 -> 1.0 with exponent + 1.
      norm_round_adj_st: begin
        frac_r <= '0;
        exp_r  <= exp_r + EXP_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result       <= '0;
      flag_zero    <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inexact <= 1'b0;
    end else if (state == norm_pack_st) begin
      flag_zero    <= 1'b0;
      flag_ovf     <= 1'b0;
      flag_unf     <= 1'b0;
      flag_inexact <= inexact_r;
      if (zero_r) begin
        result       <= {sign_r, 31'h0};
        flag_zero    <= 1'b1;
        flag_inexact <= 1'b0;
      end else if (unf_r || (exp_r <= EXP_ZERO && exp_r < EXP_INF_S)) begin
        result       <= {sign_r, 31'h0};
        flag_unf     <= 1'b1;
        flag_zero    <= 1'b1;
        flag_inexact <= 1'b1;
      end else if (exp_r >= EXP_INF_S) begin
        result   <= {sign_r, 8'hFF, 23'h0};
        flag_ovf <= 1'b1;
      end else begin
        result <= {sign_r, exp_r[7:0], frac_r};
      end
    end
  end

endmodule

// File: tb/tb_fpu_normalize_round.sv
module tb_fpu_normalize_round;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               sign_in = 1'b0;
  logic signed [9:0]  exp_in = '0;
  logic [47:0]        mant_in = '0;
  logic               ack = 1'b0;
  logic               busy, result_valid;
  logic [31:0]        result;
  logic               flag_zero, flag_ovf, flag_unf, flag_inexact;
  wire  [3:0]         flg = {flag_ovf, flag_unf, flag_zero, flag_inexact};

  fpu_normalize_round #(.MANT_IN_W(48), .EXP_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .sign_in      (sign_in),
    .exp_in       (exp_in),
    .mant_in      (mant_in),
    .busy         (busy),
    .result_valid (result_valid),
    .ack          (ack),
    .result       (result),
    .flag_zero    (flag_zero),
    .flag_ovf     (flag_ovf),
    .flag_unf     (flag_unf),
    .flag_inexact (flag_inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: value = mant * 2^(exp-127-46); round the 24 significant bits to
  // nearest-even by comparing the discarded remainder with one half ulp.
  // flags = {ovf, unf, zero, inexact}; lat = cycles from start to result_valid.
  function automatic void model(input logic s, input logic signed [9:0] e_in, input logic [47:0] m,
                                output logic [31:0] res, output logic [3:0] f, output int lat);
    int p, e, k, sh;
    logic [63:0] mm, kept, rem, half;
    logic inexact;
    e = int'(e_in);
    if (m == '0) begin
      res = {s, 31'h0}; f = 4'b0010; lat = 3; return;
    end
    p = 47;
    while (!m[p]) p--;
    k = (p < 46) ? 46 - p : 0;
    if (k > 0 && e - k <= 0) begin
      res = {s, 31'h0}; f = 4'b0111;
      lat = 3 + ((e >= 1) ? e : 1);
      return;
    end
    lat = 4 + k + ((p == 47) ? 1 : 0);
    e = e + p - 46;
    sh = p - 23;
    mm = {16'h0, m};
    if (sh > 0) begin
      kept = mm >> sh;
      rem  = mm & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
    end else begin
      kept = mm << (-sh);
      rem  = 64'd0;
      half = 64'd1;
    end
    inexact = (rem != 64'd0);
    if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
    if (kept == (64'd1 << 24)) begin
      kept = 64'd1 << 23; e = e + 1; lat = lat + 1;
    end
    if (e >= 255) begin
      res = {s, 8'hFF, 23'h0}; f = {3'b100, inexact};
    end else if (e <= 0) begin
      res = {s, 31'h0}; f = 4'b0111;
    end else begin
      res = {s, e[7:0], kept[22:0]}; f = {3'b000, inexact};
    end
  endfunction

  // Shared between driver and checker.
  logic        inflight = 1'b0;
  logic        seen = 1'b0;
  int          start_cyc = 0;
  logic [31:0] exp_res = '0;
  logic [3:0]  exp_flg = '0;
  int          exp_lat = 0;
  logic [31:0] held_res = '0;
  logic [3:0]  held_flg = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (!inflight) begin
        chk("idle_busy", busy, 1'b0);
        chk("idle_valid", result_valid, 1'b0);
        chk("idle_result", result, held_res);
        chk("idle_flags", flg, held_flg);
      end else if (!result_valid) begin
        if (seen) chk("valid_held", result_valid, 1'b1);
        else if (cyc != start_cyc) chk("busy", busy, 1'b1);
      end else begin
        if (!seen) begin
          chk("latency", cyc - start_cyc, exp_lat);
          seen = 1'b1;
        end
        chk("valid_busy", busy, 1'b0);
        chk("result", result, exp_res);
        chk("flags", flg, exp_flg);
      end
    end
  end

  task automatic recover();
    #1 rst = 1'b1; start = 1'b0; ack = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    inflight = 1'b0; held_res = '0; held_flg = '0;
  endtask

  task automatic run_op(input logic s, input logic signed [9:0] e, input logic [47:0] m,
                        input bit poke, input bit pin, input logic [31:0] lit_res,
                        input logic [3:0] lit_flg, input int lit_lat);
    logic [31:0] r;
    logic [3:0]  f;
    int          l, waited;
    model(s, e, m, r, f, l);
    if (pin) begin
      chk("model_result", r, lit_res);
      chk("model_flags", f, lit_flg);
      chk("model_latency", l, lit_lat);
    end
    @(posedge clk); #1;
    exp_res = r; exp_flg = f; exp_lat = l; seen = 1'b0; start_cyc = cyc; inflight = 1'b1;
    sign_in = s; exp_in = e; mant_in = m; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    if (poke) begin
      @(posedge clk); #1;
      start = 1'b1; sign_in = ~s; exp_in = 10'($urandom); mant_in = {16'($urandom), $urandom};
      @(posedge clk); #1 start = 1'b0;
    end
    waited = 0;
    while (!seen && waited < 100) begin
      @(posedge clk); waited++;
    end
    if (!seen) begin
      chk("valid_timeout", seen, 1'b1);
      recover();
      return;
    end
    if (poke) begin
      #1 start = 1'b1; mant_in = {16'($urandom), $urandom};
      @(posedge clk); #1 start = 1'b0;
    end
    repeat ($urandom_range(0, 2)) @(posedge clk);
    #1 ack = 1'b1;
    if (poke) begin
      start = 1'b1; mant_in = {16'($urandom), $urandom}; exp_in = 10'sd127;
    end
    @(posedge clk); #1;
    ack = 1'b0; start = 1'b0; inflight = 1'b0; held_res = r; held_flg = f;
  endtask

  initial begin
    int p, sel, t;
    logic [63:0] rnd;
    logic [47:0] m;
    logic signed [9:0] e;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    run_op(1'b0, 10'sd127, 48'd1 << 46, 1'b0, 1'b1, 32'h3F800000, 4'b0000, 4);
    run_op(1'b0, 10'sd127, (48'd1 << 47) | (48'd1 << 44), 1'b0, 1'b1, 32'h40100000, 4'b0000, 5);
    run_op(1'b0, 10'sd130, 48'd1 << 42, 1'b0, 1'b1, 32'h3F000000, 4'b0000, 8);
    run_op(1'b0, 10'sd3, 48'd1 << 42, 1'b0, 1'b1, 32'h00000000, 4'b0111, 6);
    run_op(1'b0, 10'sd127, (48'd1 << 46) | (48'd1 << 22), 1'b0, 1'b1, 32'h3F800000, 4'b0001, 4);
    run_op(1'b0, 10'sd127, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22), 1'b0, 1'b1,
           32'h3F800002, 4'b0001, 4);
    run_op(1'b0, 10'sd127, (48'd1 << 47) - (48'd1 << 22), 1'b0, 1'b1, 32'h40000000, 4'b0001, 5);
    run_op(1'b1, 10'sd300, 48'd1 << 46, 1'b0, 1'b1, 32'hFF800000, 4'b1000, 4);
    run_op(1'b1, 10'sd127, 48'd0, 1'b1, 1'b1, 32'h80000000, 4'b0010, 3);
    run_op(1'b1, 10'sd127, (48'd1 << 46) | 48'd5, 1'b1, 1'b1, 32'hBF800000, 4'b0001, 4);

    // Reset in the middle of a long left-shift sequence.
    @(posedge clk); #1;
    seen = 1'b0; start_cyc = cyc; exp_lat = 0; inflight = 1'b1;
    sign_in = 1'b1; exp_in = 10'sd200; mant_in = 48'd1 << 10; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (6) @(posedge clk);
    recover();
    run_op(1'b0, 10'sd127, 48'd1 << 46, 1'b0, 1'b0, 32'h0, 4'h0, 0);

    for (int n = 0; n < 200; n++) begin
      p = $urandom_range(0, 47);
      rnd = {$urandom, $urandom};
      m = rnd[47:0] & ((48'd1 << p) - 48'd1);
      m = m | (48'd1 << p);
      sel = $urandom_range(0, 7);
      if (sel == 0) m = '0;
      else if (sel < 3 && p >= 24) begin
        m = m & ~((48'd1 << (p - 23)) - 48'd1);
        m = m | (48'd1 << (p - 24));
      end else if (sel == 3) m = m | ((48'd1 << p) - 48'd1);
      sel = $urandom_range(0, 9);
      if (sel == 0)      t = $urandom_range(0, 40) - 20;
      else if (sel == 1) t = $urandom_range(240, 300);
      else               t = $urandom_range(1, 254);
      e = t[9:0];
      run_op(1'($urandom), e, m, 1'($urandom_range(0, 3) == 0), 1'b0, 32'h0, 4'h0, 0);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
